keypad_matrix_scan: RTL and testbench

- Upstream stage of the APB keyboard peripheral.
- Drives the 4x4 keypad row lines and samples the column lines.
- Produces per-row raw column snapshots with a ready strobe, plus a debounced 16-bit key map.
- The APB keyboard wrapper consumes row_idx/col_out/row_rdy for interrupt capture and key_state for PRDATA.

---
 rtl/keypad_matrix_scan.sv | 127 ++++++++++++
 tb/tb_keypad_matrix_scan.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// keypad_matrix_scan : 4x4 keypad row scanner with per-row samples and a
//                      debounced key map. Optional macro: KEYPAD_EVENT_EN.
// Rev 1.0
// ============================================================================
module keypad_matrix_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row,
  output logic [1:0]  row_idx,
  output logic [3:0]  col_out,
  output logic        row_rdy,
  output logic [15:0] key_state,
  output logic        key_event,
  output logic [3:0]  key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] C_DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_DEB        = CW'(DEBOUNCE_CNT);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_cur;
  logic [11:0]   r_acc;
  logic [15:0]   r_prev;
  logic [CW-1:0] r_stable;

  logic          w_sample;
  logic [15:0]   w_frame;
  logic [CW-1:0] w_stable_nxt;
  logic          w_commit;

  assign w_sample = (r_dwell == C_DWELL_LAST);
  // Row 3 is merged straight from the synchroniser so the frame is complete on its sample edge.
  assign w_frame  = {~r_sync2, r_acc};

  always_comb begin
    w_stable_nxt = CW'(1);
    if (w_frame == r_prev) begin
      w_stable_nxt = (r_stable == C_DEB) ? C_DEB : r_stable + CW'(1);
    end
  end

  assign w_commit = w_sample && (r_cur == 2'd3) && (w_stable_nxt == C_DEB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 4'b1111;
      r_sync2   <= 4'b1111;
      r_dwell   <= '0;
      r_cur     <= 2'd0;
      r_acc     <= 12'd0;
      r_prev    <= 16'd0;
      r_stable  <= '0;
      row       <= 4'b1110;
      row_idx   <= 2'd0;
      col_out   <= 4'b1111;
      row_rdy   <= 1'b0;
      key_state <= 16'd0;
    end else begin
      r_sync1 <= col_in;
      r_sync2 <= r_sync1;
      row_rdy <= w_sample;
      if (w_sample) begin
        r_dwell <= '0;
        r_cur   <= r_cur + 2'd1;
        row     <= {row[2:0], row[3]};
        col_out <= r_sync2;
        row_idx <= r_cur;
        case (r_cur)
          2'd0:    r_acc[3:0]  <= ~r_sync2;
          2'd1:    r_acc[7:4]  <= ~r_sync2;
          2'd2:    r_acc[11:8] <= ~r_sync2;
          default: ;
        endcase
        if (r_cur == 2'd3) begin
          r_prev   <= w_frame;
          r_stable <= w_stable_nxt;
        end
        if (w_commit) begin
          key_state <= w_frame;
        end
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

`ifdef KEYPAD_EVENT_EN
  logic [15:0] w_new;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[3:0];
    end
  endfunction

  assign w_new = w_frame & ~key_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_event <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_event <= 1'b0;
      if (w_commit && (w_new != 16'd0)) begin
        key_event <= 1'b1;
        key_code  <= lowest_idx(w_new);
      end
    end
  end
`else
  assign key_event = 1'b0;
  assign key_code  = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
`default_nettype none
// Testbench for keypad_matrix_scan: keypad model drives col_in from row and a
// key set; expected per-row samples go through a scoreboard queue.
module tb_keypad_matrix_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;

  typedef struct packed {
    logic [1:0]  idx;
    logic [3:0]  col;
    logic [15:0] ks;
    logic        ev;
    logic [3:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row;
  logic [1:0]  row_idx;
  logic [3:0]  col_out;
  logic        row_rdy;
  logic [15:0] key_state;
  logic        key_event;
  logic [3:0]  key_code;

  logic [15:0] keys = 16'd0;
  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;

  logic [15:0] m_prev;
  int          m_cnt;
  logic [15:0] m_state;
  logic [3:0]  m_code;

  keypad_matrix_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row(row), .row_idx(row_idx),
    .col_out(col_out), .row_rdy(row_rdy), .key_state(key_state),
    .key_event(key_event), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to a row driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!row[rr] && keys[rr*4+cc]) col_in[cc] = 1'b0;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && row_rdy) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_row_rdy t=%0t got row_idx=%0d col_out=%b required no strobe", $time, row_idx, col_out);
      end else begin
        e = q.pop_front();
        checks += 4;
        if (row_idx !== e.idx) begin
          errors++; $display("FAIL row_idx got=%0d exp=%0d t=%0t", row_idx, e.idx, $time);
        end
        if (col_out !== e.col) begin
          errors++; $display("FAIL col_out row=%0d got=%b exp=%b t=%0t", e.idx, col_out, e.col, $time);
        end
        if (key_state !== e.ks) begin
          errors++; $display("FAIL key_state row=%0d got=%h exp=%h t=%0t", e.idx, key_state, e.ks, $time);
        end
        if (key_event !== e.ev || key_code !== e.code) begin
          errors++; $display("FAIL key_event/code got=%b/%0d exp=%b/%0d t=%0t", key_event, key_code, e.ev, e.code, $time);
        end
      end
    end else if (rst_n) begin
      checks++;
      if (key_event !== 1'b0) begin
        errors++; $display("FAIL key_event_idle got=%b exp=0 t=%0t", key_event, $time);
      end
    end
  end

  task automatic frame_update(input logic [15:0] f, output logic ev);
    logic [15:0] nw;
    logic found;
    ev = 1'b0;
    if (f == m_prev) m_cnt = (m_cnt >= DEB) ? DEB : m_cnt + 1;
    else             m_cnt = 1;
    m_prev = f;
    if (m_cnt == DEB) begin
`ifdef KEYPAD_EVENT_EN
      nw = f & ~m_state;
      found = 1'b0;
      for (int b = 0; b < 16; b++) begin
        if (nw[b] && !found) begin
          found = 1'b1;
          m_code = b[3:0];
        end
      end
      ev = found;
`else
      nw = 16'd0;
      found = 1'b0;
`endif
      m_state = f;
    end
  endtask

  // Scan nrows rows (starting at row 0) with a constant key set.
  task automatic run_rows(input logic [15:0] k, input int nrows);
    exp_t e;
    logic [3:0] exp_row;
    logic ev;
    int r;
    keys = k;
    for (int i = 0; i < nrows; i++) begin
      r = i % 4;
      e.idx = r[1:0];
      e.col = ~k[4*r +: 4];
      ev = 1'b0;
      if (r == 3) frame_update(k, ev);
      e.ev = ev;
      e.ks = m_state;
      e.code = m_code;
      q.push_back(e);
      exp_row = ~(4'b0001 << r);
      for (int c = 0; c < SCAN_DIV; c++) begin
        checks++;
        if (row !== exp_row) begin
          errors++; $display("FAIL row_drive r=%0d c=%0d got=%b exp=%b", r, c, row, exp_row);
        end
        @(negedge clk);
      end
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (row !== 4'b1110 || row_idx !== 2'd0 || col_out !== 4'b1111 || row_rdy !== 1'b0 ||
        key_state !== 16'd0 || key_event !== 1'b0 || key_code !== 4'd0) begin
      errors++;
      $display("FAIL reset_values got row=%b idx=%0d col=%b rdy=%b ks=%h ev=%b code=%0d exp row=1110 idx=0 col=1111 rdy=0 ks=0000 ev=0 code=0",
               row, row_idx, col_out, row_rdy, key_state, key_event, key_code);
    end
    repeat (cycles) @(negedge clk);
    q.delete();
    m_prev = 16'd0; m_cnt = 0; m_state = 16'd0; m_code = 4'd0;
    rst_n = 1'b1;
  endtask

  task automatic check_final(input string name, input logic [15:0] ks, input logic [3:0] code);
    logic [3:0] exp_code;
`ifdef KEYPAD_EVENT_EN
    exp_code = code;
`else
    exp_code = 4'd0;
`endif
    checks += 2;
    if (key_state !== ks) begin
      errors++; $display("FAIL %s key_state got=%h exp=%h", name, key_state, ks);
    end
    if (key_code !== exp_code) begin
      errors++; $display("FAIL %s key_code got=%0d exp=%0d", name, key_code, exp_code);
    end
  endtask

  task automatic test_reset();
    keys = 16'd0;
    apply_reset(3);
  endtask

  task automatic test_no_keys();
    apply_reset(2);
    run_rows(16'd0, 8);
    check_final("no_keys", 16'h0000, 4'd0);
  endtask

  task automatic test_hold_key6();
    apply_reset(2);
    run_rows(16'h0040, 4);
    check_final("key6_frame1", 16'h0000, 4'd0);
    run_rows(16'h0040, 4);
    check_final("key6_frame2", 16'h0040, 4'd6);
  endtask

  task automatic test_short_press();
    apply_reset(2);
    run_rows(16'h0040, 4);
    run_rows(16'h0000, 8);
    check_final("short_press", 16'h0000, 4'd0);
  endtask

  task automatic test_two_keys();
    apply_reset(2);
    run_rows(16'h8001, 8);
    check_final("two_keys", 16'h8001, 4'd0);
  endtask

  task automatic test_release();
    apply_reset(2);
    run_rows(16'h0040, 8);
    check_final("release_before", 16'h0040, 4'd6);
    run_rows(16'h0000, 4);
    check_final("release_frame1", 16'h0040, 4'd6);
    run_rows(16'h0000, 4);
    check_final("release_frame2", 16'h0000, 4'd6);
  endtask

  task automatic test_reset_mid_frame();
    apply_reset(2);
    run_rows(16'h0040, 14);
    check_final("mid_before", 16'h0040, 4'd6);
    repeat (2) @(negedge clk);
    apply_reset(1);
    run_rows(16'h0040, 4);
    check_final("mid_after_frame1", 16'h0000, 4'd0);
    run_rows(16'h0040, 4);
    check_final("mid_after_frame2", 16'h0040, 4'd6);
  endtask

  initial begin
    m_prev = 16'd0; m_cnt = 0; m_state = 16'd0; m_code = 4'd0;
    test_reset();
    test_no_keys();
    test_hold_key6();
    test_short_press();
    test_two_keys();
    test_release();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
